// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, times multi-cycle
// mult/div/madd operations and requests D-stage stalls for MD-class hazards.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   pend_hi_r;
    logic [31:0]   pend_lo_r;
    logic [63:0]   calc_s;
    logic          is_calc_s;
    logic          is_div_s;
    logic [CW-1:0] cycles_s;

    function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{x[31]}}, x};
        ye = {{32{y[31]}}, y};
        return xe * ye;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Returns {remainder, quotient}; sign-magnitude form keeps the
    // 0x80000000 / -1 case well defined (quotient wraps back to 0x80000000).
    function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mag_x;
        logic [31:0] mag_y;
        logic [31:0] q;
        logic [31:0] r;
        mag_x = x[31] ? (32'd0 - x) : x;
        mag_y = y[31] ? (32'd0 - y) : y;
        q = mag_x / mag_y;
        r = mag_x % mag_y;
        if (x[31] ^ y[31]) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (x[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    assign is_calc_s = (op <= 3'd4);
    assign is_div_s  = (op == 3'd2) || (op == 3'd3);
    assign cycles_s  = is_div_s ? CNT_DIV : CNT_MULT;

    // Candidate {hi,lo} result for the operation presented this cycle.
    always_comb begin
        calc_s = {hi_r, lo_r};
        case (op)
            3'd0: calc_s = mul_signed(a, b);
            3'd1: calc_s = mul_unsigned(a, b);
            3'd2: begin
                if (b != 32'd0) begin
                    calc_s = div_signed(a, b);
                end else begin
                    calc_s = {hi_r, lo_r};
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    calc_s = div_unsigned(a, b);
                end else begin
                    calc_s = {hi_r, lo_r};
                end
            end
            3'd4: calc_s = {hi_r, lo_r} + mul_signed(a, b);
            default: calc_s = {hi_r, lo_r};
        endcase
    end

    // Sequencer: launches operations, counts the busy window, commits HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                                pend_hi_r <= calc_s[63:32];
                                pend_lo_r <= calc_s[31:0];
                                cnt_r     <= cycles_s;
                                busy_r    <= 1'b1;
                                state_r   <= ST_RUN;
                            end
                            3'd5: hi_r <= a;
                            3'd6: lo_r <= a;
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A start here is a hazard-unit violation and is dropped.
                    if (cnt_r == CNT_ONE) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign md_stall = d_md & (busy_r | (start & is_calc_s));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_md_unit_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // behavioural model state
    logic [31:0] m_hi, m_lo, m_p_hi, m_p_lo;
    bit          m_busy;
    int          edge_n;
    int          m_end;
    bit          viol;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .d_md(d_md), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        m_busy = 1'b0;
    endtask

    // Model of one rising edge, driven by the inputs held during the cycle.
    task automatic model_edge();
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] acc;
        edge_n++;
        sa = $signed(a);
        sb = $signed(b);
        if (m_busy) begin
            if (start) viol = 1'b1;
            if (edge_n == m_end) begin
                m_hi = m_p_hi;
                m_lo = m_p_lo;
                m_busy = 1'b0;
            end
        end else if (start) begin
            acc = {m_hi, m_lo};
            case (op)
                3'd0: acc = sa * sb;
                3'd1: acc = {32'd0, a} * {32'd0, b};
                3'd4: acc = {m_hi, m_lo} + sa * sb;
                3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
                3'd3: if (b != 32'd0) acc = {a % b, a / b};
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
            if (op <= 3'd4) begin
                m_p_hi = acc[63:32];
                m_p_lo = acc[31:0];
                m_busy = 1'b1;
                m_end  = edge_n + ((op == 3'd2 || op == 3'd3) ? DC : MC);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else model_edge();
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'd7;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            n++;
            tick();
        end
        check32("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Every-cycle comparison of the DUT against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check32("busy", {31'd0, busy}, {31'd0, m_busy});
            check32("hi", hi, m_hi);
            check32("lo", lo, m_lo);
            check32("md_stall", {31'd0, md_stall},
                    {31'd0, d_md & (m_busy | (start & (op <= 3'd4)))});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0; d_md = 1'b1;
        viol = 1'b0; edge_n = 0; m_end = 0; m_p_hi = 32'd0; m_p_lo = 32'd0;
        model_clear();
        tick(); tick();
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b0; d_md = 1'b0;
        chk_en = 1'b1;

        // 1: reset in the middle of a MULT
        issue(3'd5, 32'h0000_AAAA, 32'd0);
        issue(3'd6, 32'h0000_5555, 32'd0);
        d_md = 1'b1;
        issue(3'd0, 32'd3, 32'd4);
        tick(); tick();
        reset = 1'b1;
        #1;
        model_clear();
        check32("t1_hi", hi, 32'd0);
        check32("t1_lo", lo, 32'd0);
        check32("t1_busy", {31'd0, busy}, 32'd0);
        check32("t1_stall", {31'd0, md_stall}, 32'd0);
        tick(); tick();
        reset = 1'b0; d_md = 1'b0;
        repeat (12) tick();
        check32("t1_hi_late", hi, 32'd0);
        check32("t1_lo_late", lo, 32'd0);

        // 2: signed and unsigned multiply
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check32("t2_mult_cycles", n, 32'd5);
        check32("t2_mult_hi", hi, 32'hFFFF_FFFF);
        check32("t2_mult_lo", lo, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check32("t2_multu_hi", hi, 32'h0000_0002);
        check32("t2_multu_lo", lo, 32'hFFFF_FFFA);

        // 3: divides, including divide-by-zero and overflow
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check32("t3_div_cycles", n, 32'd10);
        check32("t3_div_lo", lo, 32'hFFFF_FFFD);
        check32("t3_div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check32("t3_divu_lo", lo, 32'd3);
        check32("t3_divu_hi", hi, 32'd1);
        issue(3'd2, 32'd99, 32'd0);
        wait_idle(n);
        check32("t3_div0_cycles", n, 32'd10);
        check32("t3_div0_lo", lo, 32'd3);
        check32("t3_div0_hi", hi, 32'd1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check32("t3_ovf_lo", lo, 32'h8000_0000);
        check32("t3_ovf_hi", hi, 32'd0);

        // 4: MADD carry across LO into HI, then MTHI
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd6, 32'hFFFF_FFFF, 32'd0);
        issue(3'd4, 32'd1, 32'd1);
        wait_idle(n);
        check32("t4_madd_cycles", n, 32'd5);
        check32("t4_madd_hi", hi, 32'd1);
        check32("t4_madd_lo", lo, 32'd0);
        issue(3'd5, 32'h0000_1234, 32'd0);
        check32("t4_mthi_hi", hi, 32'h0000_1234);
        check32("t4_mthi_busy", {31'd0, busy}, 32'd0);
        check32("t4_mthi_lo", lo, 32'd0);

        // 5: stall window with and without a D-stage MD instruction
        d_md = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        #1;
        check32("t5_stall_start", {31'd0, md_stall}, 32'd1);
        tick();
        start = 1'b0; op = 3'd7;
        n = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            if (md_stall === 1'b1) n++;
            tick();
        end
        check32("t5_stall_cycles", n, 32'd5);
        check32("t5_stall_end", {31'd0, md_stall}, 32'd0);
        d_md = 1'b0;
        issue(3'd0, 32'd2, 32'd2);
        n = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            if (md_stall === 1'b1) n++;
            tick();
        end
        check32("t5_nostall", n, 32'd0);

        // 6: start during busy is dropped and flagged
        viol = 1'b0;
        issue(3'd0, 32'd5, 32'd7);
        issue(3'd2, 32'd100, 32'd3);
        wait_idle(n);
        check32("t6_rest_cycles", n, 32'd4);
        check32("t6_hi", hi, 32'd0);
        check32("t6_lo", lo, 32'd35);
        check32("t6_violation_flag", {31'd0, viol}, 32'd1);

        // randomized traffic, never starting while the model is busy
        viol = 1'b0;
        for (int i = 0; i < 800; i++) begin
            d_md = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            op = 3'($urandom_range(0, 7));
            start = (!m_busy && ($urandom_range(0, 2) == 0));
            tick();
        end
        start = 1'b0;
        wait_idle(n);
        check32("rand_violation_flag", {31'd0, viol}, 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
